// File: rtl/apu_pkg.sv
// Shared constants for the APU voices.
//   LEN_TABLE  : length counter load values, indexed by len_idx (reg_3[7:3])
//   DUTY_TABLE : duty waveforms, bit n is the output level at sequencer step n
//   R*_*       : bit positions of the fields in the four channel registers
package apu_pkg;

  localparam logic [7:0] LEN_TABLE [0:31] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  localparam logic [7:0] DUTY_TABLE [0:3] = '{
    8'b0000_0010,
    8'b0000_0110,
    8'b0001_1110,
    8'b1111_1001
  };

  localparam int R0_DUTY_LSB = 6;
  localparam int R0_HALT_BIT = 5;
  localparam int R0_CVOL_BIT = 4;
  localparam int R1_EN_BIT   = 7;
  localparam int R1_P_LSB    = 4;
  localparam int R1_NEG_BIT  = 3;
  localparam int R3_LEN_LSB  = 3;

endpackage

// File: rtl/apu_envelope.sv
// Envelope generator: start flag, divider and 15..0 decay level.
// Ports: apu_clk/rst_n clock and async active-low reset; qtr_tick steps the
// envelope; start_set requests a restart (serviced on the next qtr_tick);
// vol_v is the volume/divider-period field; loop_en reloads decay after 0;
// const_vol selects vol_v directly; volume is the resulting 4-bit level.
module apu_envelope (
  input  logic       apu_clk,
  input  logic       rst_n,
  input  logic       qtr_tick,
  input  logic       start_set,
  input  logic [3:0] vol_v,
  input  logic       loop_en,
  input  logic       const_vol,
  output logic [3:0] volume
);

  logic       start_q, start_d;
  logic [3:0] decay_q, decay_d;
  logic [3:0] div_q, div_d;

  always_comb begin
    start_d = start_q;
    decay_d = decay_q;
    div_d   = div_q;
    if (qtr_tick) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = 4'd15;
        div_d   = vol_v;
      end else if (div_q == 4'd0) begin
        div_d = vol_v;
        if (decay_q != 4'd0) decay_d = decay_q - 4'd1;
        else if (loop_en)    decay_d = 4'd15;
      end else begin
        div_d = div_q - 4'd1;
      end
    end
    // A restart arriving with a quarter tick waits for the following tick.
    if (start_set) start_d = 1'b1;
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      decay_q <= 4'd0;
      div_q   <= 4'd0;
    end else begin
      start_q <= start_d;
      decay_q <= decay_d;
      div_q   <= div_d;
    end
  end

  assign volume = const_vol ? vol_v : decay_q;

endmodule

// File: rtl/pulse_voice.sv
// Square-wave voice: register file, prescaled period timer, 8-step duty
// sequencer, length counter, sweep unit and envelope.
// Ports: apu_clk/rst_n clock and async active-low reset; qtr_tick/hlf_tick
// frame strobes; wr_en one-hot reg_0..reg_3 write strobe with wr_data;
// chan_en channel enable; pulse_out registered 5-bit sample; active is
// length counter nonzero.
module pulse_voice
  import apu_pkg::*;
#(
  parameter int unsigned TIMER_DIV  = 2,
  parameter int unsigned NEG_ONES   = 0,
  parameter int unsigned SIGNED_OUT = 1
) (
  input  logic       apu_clk,
  input  logic       rst_n,
  input  logic       qtr_tick,
  input  logic       hlf_tick,
  input  logic [3:0] wr_en,
  input  logic [7:0] wr_data,
  input  logic       chan_en,
  output logic [4:0] pulse_out,
  output logic       active
);

  logic [1:0]  duty_q, duty_d;
  logic        halt_q, halt_d;
  logic        cvol_q, cvol_d;
  logic [3:0]  vol_q, vol_d;
  logic        sw_en_q, sw_en_d;
  logic [2:0]  sw_p_q, sw_p_d;
  logic        sw_neg_q, sw_neg_d;
  logic [2:0]  sw_shift_q, sw_shift_d;
  logic [10:0] period_q, period_d;
  logic [7:0]  length_q, length_d;
  logic [2:0]  step_q, step_d;
  logic [10:0] timer_q, timer_d;
  logic [3:0]  presc_q, presc_d;
  logic [2:0]  sw_div_q, sw_div_d;
  logic        sw_reload_q, sw_reload_d;
  logic [4:0]  pulse_out_q, pulse_out_d;

  logic [11:0] shifted, target;
  logic        mute, presc_tick, duty_bit;
  logic [3:0]  volume;
  logic [4:0]  vol5;

  apu_envelope u_env (
    .apu_clk   (apu_clk),
    .rst_n     (rst_n),
    .qtr_tick  (qtr_tick),
    .start_set (wr_en[3]),
    .vol_v     (vol_q),
    .loop_en   (halt_q),
    .const_vol (cvol_q),
    .volume    (volume)
  );

  assign shifted = {1'b0, period_q} >> sw_shift_q;
  // Negate mode wraps on underflow only when shift is 0, where no update happens.
  assign target  = sw_neg_q ? ({1'b0, period_q} - shifted - 12'(NEG_ONES))
                            : ({1'b0, period_q} + shifted);
  assign mute    = (period_q < 11'd8) | (!sw_neg_q & target[11]);

  assign presc_tick = (presc_q == 4'd0);
  assign duty_bit   = DUTY_TABLE[duty_q][step_q];
  assign vol5       = {1'b0, volume};

  always_comb begin
    duty_d      = duty_q;
    halt_d      = halt_q;
    cvol_d      = cvol_q;
    vol_d       = vol_q;
    sw_en_d     = sw_en_q;
    sw_p_d      = sw_p_q;
    sw_neg_d    = sw_neg_q;
    sw_shift_d  = sw_shift_q;
    period_d    = period_q;
    length_d    = length_q;
    step_d      = step_q;
    timer_d     = timer_q;
    presc_d     = presc_q;
    sw_div_d    = sw_div_q;
    sw_reload_d = sw_reload_q;
    pulse_out_d = 5'd0;

    presc_d = presc_tick ? 4'(TIMER_DIV - 1) : presc_q - 4'd1;
    if (presc_tick) begin
      if (timer_q == 11'd0) begin
        timer_d = period_q;
        step_d  = step_q + 3'd1;
      end else begin
        timer_d = timer_q - 11'd1;
      end
    end

    if (hlf_tick) begin
      if (!halt_q && length_q != 8'd0) length_d = length_q - 8'd1;
      if (sw_div_q == 3'd0 && sw_en_q && sw_shift_q != 3'd0 && !mute)
        period_d = target[10:0];
      if (sw_div_q == 3'd0 || sw_reload_q) begin
        sw_div_d    = sw_p_q;
        sw_reload_d = 1'b0;
      end else begin
        sw_div_d = sw_div_q - 3'd1;
      end
    end

    // Register writes come last so they override tick-driven updates.
    if (wr_en[0]) begin
      duty_d = wr_data[R0_DUTY_LSB +: 2];
      halt_d = wr_data[R0_HALT_BIT];
      cvol_d = wr_data[R0_CVOL_BIT];
      vol_d  = wr_data[3:0];
    end
    if (wr_en[1]) begin
      sw_en_d     = wr_data[R1_EN_BIT];
      sw_p_d      = wr_data[R1_P_LSB +: 3];
      sw_neg_d    = wr_data[R1_NEG_BIT];
      sw_shift_d  = wr_data[2:0];
      sw_reload_d = 1'b1;
    end
    if (wr_en[2]) period_d[7:0] = wr_data;
    if (wr_en[3]) begin
      period_d[10:8] = wr_data[2:0];
      step_d         = 3'd0;
      if (chan_en) length_d = LEN_TABLE[wr_data[R3_LEN_LSB +: 5]];
    end
    if (!chan_en) length_d = 8'd0;

    if (length_q != 8'd0 && !mute) begin
      if (duty_bit)              pulse_out_d = vol5;
      else if (SIGNED_OUT != 0)  pulse_out_d = 5'd0 - vol5;
    end
  end

  always_ff @(posedge apu_clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q      <= '0;
      halt_q      <= 1'b0;
      cvol_q      <= 1'b0;
      vol_q       <= '0;
      sw_en_q     <= 1'b0;
      sw_p_q      <= '0;
      sw_neg_q    <= 1'b0;
      sw_shift_q  <= '0;
      period_q    <= '0;
      length_q    <= '0;
      step_q      <= '0;
      timer_q     <= '0;
      presc_q     <= '0;
      sw_div_q    <= '0;
      sw_reload_q <= 1'b0;
      pulse_out_q <= '0;
    end else begin
      duty_q      <= duty_d;
      halt_q      <= halt_d;
      cvol_q      <= cvol_d;
      vol_q       <= vol_d;
      sw_en_q     <= sw_en_d;
      sw_p_q      <= sw_p_d;
      sw_neg_q    <= sw_neg_d;
      sw_shift_q  <= sw_shift_d;
      period_q    <= period_d;
      length_q    <= length_d;
      step_q      <= step_d;
      timer_q     <= timer_d;
      presc_q     <= presc_d;
      sw_div_q    <= sw_div_d;
      sw_reload_q <= sw_reload_d;
      pulse_out_q <= pulse_out_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign active    = (length_q != 8'd0);

endmodule
